// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback FIFO arbiter (LSU over ALU) with per-register pending-write scoreboard
module wb_arbiter #(
  parameter int BITSIZE = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rstn_i,
  input  logic               flush_i,
  input  logic               issue_valid_i,
  input  logic [4:0]         issue_rd_i,
  input  logic               alu_valid_i,
  output logic               alu_ready_o,
  input  logic [4:0]         alu_rd_i,
  input  logic [BITSIZE-1:0] alu_data_i,
  input  logic               lsu_valid_i,
  output logic               lsu_ready_o,
  input  logic [4:0]         lsu_rd_i,
  input  logic [BITSIZE-1:0] lsu_data_i,
  input  logic [4:0]         rs1_i,
  input  logic [4:0]         rs2_i,
  output logic               rs1_busy_o,
  output logic               rs2_busy_o,
  output logic               rf_we_o,
  output logic [4:0]         rf_rd_o,
  output logic [BITSIZE-1:0] rf_data_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [4:0]         fifo_rd_q   [DEPTH];
  logic [BITSIZE-1:0] fifo_data_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         pend_q [32];
  logic [1:0]         pend_d [32];

  logic               full, empty, lsu_acc, alu_acc, push, pop;
  logic [4:0]         push_rd, head_rd;
  logic [BITSIZE-1:0] push_data;
  logic [31:0]        inc_vec, dec_vec;

  function automatic logic reserved(input logic [4:0] r);
    return (r == 5'd0) || (r == 5'd31);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Readies are gated by rstn_i so they drop the moment reset asserts.
  assign lsu_ready_o = rstn_i && !full && !flush_i;
  assign alu_ready_o = rstn_i && !full && !flush_i && !lsu_valid_i;

  assign lsu_acc   = lsu_valid_i && lsu_ready_o;
  assign alu_acc   = alu_valid_i && alu_ready_o;
  assign push_rd   = lsu_acc ? lsu_rd_i : alu_rd_i;
  assign push_data = lsu_acc ? lsu_data_i : alu_data_i;
  assign push      = (lsu_acc || alu_acc) && !reserved(push_rd);
  assign pop       = !empty;
  assign head_rd   = fifo_rd_q[rd_ptr_q];

  assign rf_we_o   = !empty;
  assign rf_rd_o   = empty ? '0 : head_rd;
  assign rf_data_o = empty ? '0 : fifo_data_q[rd_ptr_q];

  assign rs1_busy_o = (pend_q[rs1_i] != 2'd0);
  assign rs2_busy_o = (pend_q[rs2_i] != 2'd0);

  assign inc_vec = (issue_valid_i && !reserved(issue_rd_i)) ? (32'd1 << issue_rd_i) : 32'd0;
  assign dec_vec = pop ? (32'd1 << head_rd) : 32'd0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Counters saturate at 3 and floor at 0; a same-edge inc and dec cancel.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      pend_d[i] = pend_q[i];
      if (flush_i) begin
        pend_d[i] = 2'd0;
      end else if (inc_vec[i] && !dec_vec[i]) begin
        if (pend_q[i] != 2'd3) pend_d[i] = pend_q[i] + 2'd1;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (pend_q[i] != 2'd0) pend_d[i] = pend_q[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < 32; i++) pend_q[i] <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < 32; i++) pend_q[i] <= pend_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= push_rd;
      fifo_data_q[wr_ptr_q] <= push_data;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter with directed and randomized stimulus
module tb_wb_arbiter;
  localparam int BITSIZE = 32;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstn_i, flush_i, issue_valid_i;
  logic [4:0]         issue_rd_i;
  logic               alu_valid_i, alu_ready_o, lsu_valid_i, lsu_ready_o;
  logic [4:0]         alu_rd_i, lsu_rd_i, rs1_i, rs2_i;
  logic [BITSIZE-1:0] alu_data_i, lsu_data_i;
  logic               rs1_busy_o, rs2_busy_o, rf_we_o;
  logic [4:0]         rf_rd_o;
  logic [BITSIZE-1:0] rf_data_o;

  wb_arbiter #(.BITSIZE(BITSIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn_i(rstn_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o)
  );

  typedef struct packed {
    logic [4:0]         rd;
    logic [BITSIZE-1:0] data;
  } wr_t;

  // Reference model: expected write queue plus pending count per register.
  wr_t exp_q[$];
  int  cnt_m [32];
  bit  pop_pending = 1'b0;
  int  n_checks = 0;
  int  n_fail = 0;

  function automatic bit rsv(input logic [4:0] r);
    return (r == 5'd0) || (r == 5'd31);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < 32; i++) cnt_m[i] = 0;
    pop_pending = 1'b0;
  endtask

  // Predictor: applies the edge's accept/issue/flush rules to the model.
  always @(posedge clk) begin : predictor
    int  occ;
    bit  full_m;
    if (rstn_i) begin
      occ    = exp_q.size() + int'(pop_pending);
      full_m = (occ == DEPTH);
      if (flush_i) begin
        clear_model();
      end else begin
        if (lsu_valid_i && !full_m) begin
          if (!rsv(lsu_rd_i)) exp_q.push_back({lsu_rd_i, lsu_data_i});
        end else if (alu_valid_i && !full_m) begin
          if (!rsv(alu_rd_i)) exp_q.push_back({alu_rd_i, alu_data_i});
        end
        if (issue_valid_i && !rsv(issue_rd_i)) begin
          chk("issue_below_sat", cnt_m[issue_rd_i] < 3, 1'b1);
          if (cnt_m[issue_rd_i] < 3) cnt_m[issue_rd_i]++;
        end
      end
      pop_pending = 1'b0;
    end
  end

  // Monitor: compares DUT outputs against the model and pops presented writes.
  always @(negedge clk) begin : monitor
    int  occ;
    wr_t e;
    occ = exp_q.size();
    chk("lsu_ready", lsu_ready_o, rstn_i && (occ < DEPTH) && !flush_i);
    chk("alu_ready", alu_ready_o, rstn_i && (occ < DEPTH) && !flush_i && !lsu_valid_i);
    chk("rs1_busy", rs1_busy_o, cnt_m[rs1_i] != 0);
    chk("rs2_busy", rs2_busy_o, cnt_m[rs2_i] != 0);
    if (occ == 0) begin
      chk("rf_we_idle", rf_we_o, 1'b0);
      chk("rf_rd_idle", rf_rd_o, 5'd0);
      chk("rf_data_idle", rf_data_o, '0);
    end else begin
      e = exp_q.pop_front();
      chk("rf_we", rf_we_o, 1'b1);
      chk("rf_rd", rf_rd_o, e.rd);
      chk("rf_data", rf_data_o, e.data);
      chk("dec_nonzero", cnt_m[e.rd] != 0, 1'b1);
      if (cnt_m[e.rd] > 0) cnt_m[e.rd]--;
      pop_pending = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i = 1'b0; issue_valid_i = 1'b0; alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle();
    issue_valid_i = 1'b1; issue_rd_i = rd;
    step();
    issue_valid_i = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [BITSIZE-1:0] d);
    idle();
    alu_valid_i = 1'b1; alu_rd_i = rd; alu_data_i = d;
    step();
    alu_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  owed[$];
    int  r;
    bit  lsu_took, alu_took;
    clear_model();
    rstn_i = 1'b0; idle();
    issue_rd_i = '0; alu_rd_i = '0; lsu_rd_i = '0; alu_data_i = '0; lsu_data_i = '0;
    rs1_i = '0; rs2_i = '0;
    step(); step();
    chk("reset_we", rf_we_o, 1'b0);
    chk("reset_rd", rf_rd_o, 5'd0);
    chk("reset_data", rf_data_o, '0);
    chk("reset_lsu_ready", lsu_ready_o, 1'b0);
    chk("reset_alu_ready", alu_ready_o, 1'b0);
    rstn_i = 1'b1;
    step();

    // Basic single write with hazard visibility
    rs1_i = 5'd5;
    issue(5'd5);
    chk("t1_busy_before", rs1_busy_o, 1'b1);
    alu(5'd5, 32'hDEADBEEF);
    chk("t1_busy_inflight", rs1_busy_o, 1'b1);
    chk("t1_we", rf_we_o, 1'b1);
    chk("t1_rd", rf_rd_o, 5'd5);
    chk("t1_data", rf_data_o, 32'hDEADBEEF);
    step();
    chk("t1_busy_after", rs1_busy_o, 1'b0);
    chk("t1_we_after", rf_we_o, 1'b0);

    // LSU priority over ALU
    issue(5'd3); issue(5'd4);
    alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'h33;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd4; lsu_data_i = 32'h44;
    #1;
    chk("t2_lsu_ready", lsu_ready_o, 1'b1);
    chk("t2_alu_ready", alu_ready_o, 1'b0);
    step();
    lsu_valid_i = 1'b0;
    #1;
    chk("t2_alu_ready_later", alu_ready_o, 1'b1);
    chk("t2_first_rd", rf_rd_o, 5'd4);
    step();
    alu_valid_i = 1'b0;
    chk("t2_second_rd", rf_rd_o, 5'd3);
    step();

    // Back-to-back results across pointer wrap
    for (int k = 0; k < 8; k++) issue(5'(8 + k));
    for (int k = 0; k < 8; k++) alu(5'(8 + k), $urandom);
    step(); step();

    // Reserved destinations
    rs1_i = 5'd0; rs2_i = 5'd31;
    issue(5'd0);
    issue(5'd31);
    alu(5'd0, 32'h1111);
    chk("t4_we_x0", rf_we_o, 1'b0);
    idle(); lsu_valid_i = 1'b1; lsu_rd_i = 5'd31; lsu_data_i = 32'h2222;
    step(); lsu_valid_i = 1'b0;
    chk("t4_we_x31", rf_we_o, 1'b0);
    chk("t4_busy31", rs2_busy_o, 1'b0);

    // Double issue to one register
    rs1_i = 5'd7;
    issue(5'd7); issue(5'd7);
    alu(5'd7, 32'hA);
    step();
    chk("t5_busy_one_left", rs1_busy_o, 1'b1);
    alu(5'd7, 32'hB);
    chk("t5_busy_inflight", rs1_busy_o, 1'b1);
    step();
    chk("t5_busy_clear", rs1_busy_o, 1'b0);

    // Flush
    rs1_i = 5'd23; rs2_i = 5'd20;
    issue(5'd20); issue(5'd21); issue(5'd22); issue(5'd23); issue(5'd23);
    alu(5'd20, 32'h20); alu(5'd21, 32'h21); alu(5'd22, 32'h22);
    flush_i = 1'b1; alu_valid_i = 1'b1; alu_rd_i = 5'd23; alu_data_i = 32'h23;
    issue_valid_i = 1'b1; issue_rd_i = 5'd23;
    #1;
    chk("t6_busy_pre", rs1_busy_o, 1'b1);
    chk("t6_alu_ready_flush", alu_ready_o, 1'b0);
    chk("t6_lsu_ready_flush", lsu_ready_o, 1'b0);
    step();
    idle();
    chk("t6_we_post", rf_we_o, 1'b0);
    chk("t6_busy1_post", rs1_busy_o, 1'b0);
    chk("t6_busy2_post", rs2_busy_o, 1'b0);

    // Asynchronous reset mid-stream
    rs1_i = 5'd24;
    issue(5'd24);
    alu(5'd24, 32'h24);
    chk("t7_we_pre", rf_we_o, 1'b1);
    #2;
    rstn_i = 1'b0;
    clear_model();
    #1;
    chk("t7_we", rf_we_o, 1'b0);
    chk("t7_rd", rf_rd_o, 5'd0);
    chk("t7_data", rf_data_o, '0);
    chk("t7_busy", rs1_busy_o, 1'b0);
    chk("t7_lsu_ready", lsu_ready_o, 1'b0);
    chk("t7_alu_ready", alu_ready_o, 1'b0);
    step();
    rstn_i = 1'b1;
    step();

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      idle();
      rs1_i = 5'($urandom_range(0, 31));
      rs2_i = 5'($urandom_range(1, 6));
      if ($urandom_range(0, 59) == 0) begin
        flush_i = 1'b1;
        owed.delete();
      end else begin
        r = $urandom_range(1, 6);
        if ($urandom_range(0, 2) == 0 && cnt_m[r] < 3) begin
          issue_valid_i = 1'b1; issue_rd_i = 5'(r);
          owed.push_back(r);
        end
        if (owed.size() > 0 && $urandom_range(0, 1) == 0) begin
          lsu_valid_i = 1'b1; lsu_rd_i = 5'(owed[0]); lsu_data_i = $urandom;
        end
        if ($urandom_range(0, 1) == 0) begin
          alu_valid_i = 1'b1; alu_data_i = $urandom;
          if (owed.size() > 1) alu_rd_i = 5'(owed[1]);
          else alu_rd_i = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31;
        end
      end
      #1;
      lsu_took = lsu_valid_i && lsu_ready_o;
      alu_took = alu_valid_i && alu_ready_o;
      if (alu_took && owed.size() > 1) owed.delete(1);
      if (lsu_took) owed.delete(0);
      @(posedge clk);
      #1;
    end
    idle();
    for (int k = 0; k < 8; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
